// File: rtl/pending_encoder_32to5_pkg.sv
// Shared definitions for the 32-line pending request encoder.
//   ID_W    : width of a request index (5)
//   N_REQ   : number of request lines (32)
//   state_t : presenter state (IDLE / PRESENT)
//   id_to_onehot : expands an index into a one-hot line vector
package pending_encoder_32to5_pkg;

  localparam int unsigned ID_W  = 5;
  localparam int unsigned N_REQ = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    return N_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/pending_encoder_32to5_if.sv
// Request/present bus of the pending encoder.
//   req_i, mask_i, clr_all_i : request pulses, per-line enables, global clear
//   out_valid_o, out_id_o    : presented index (valid/ready output side)
//   out_ready_i              : consumer acceptance
//   pending_o, any_pending_o : pending register and OR of unmasked pending bits
// slave  : the encoder itself
// master : the request sources / consumer driving it
interface pending_encoder_32to5_if;
  import pending_encoder_32to5_pkg::*;

  logic [N_REQ-1:0] req_i;
  logic [N_REQ-1:0] mask_i;
  logic             clr_all_i;
  logic             out_valid_o;
  logic [ID_W-1:0]  out_id_o;
  logic             out_ready_i;
  logic [N_REQ-1:0] pending_o;
  logic             any_pending_o;

  modport slave (
    input  req_i, mask_i, clr_all_i, out_ready_i,
    output out_valid_o, out_id_o, pending_o, any_pending_o
  );

  modport master (
    output req_i, mask_i, clr_all_i, out_ready_i,
    input  out_valid_o, out_id_o, pending_o, any_pending_o
  );
endinterface

// File: rtl/pending_encoder_32to5_priority_enc.sv
// Combinational find-first-set over a 32-bit vector.
//   vec   : candidate lines
//   idx   : index of the winning line (0 when nothing is set)
//   found : at least one line of vec is set
// LSB_FIRST=1 picks the lowest set index, LSB_FIRST=0 the highest.
module priority_enc_32to5
  import pending_encoder_32to5_pkg::*;
#(
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic [N_REQ-1:0] vec,
  output logic [ID_W-1:0]  idx,
  output logic             found
);

  // Scan from the lowest-priority end so the last hit (highest priority) wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    if (LSB_FIRST != 0) begin
      for (int unsigned i = N_REQ; i > 0; i--) begin
        if (vec[i-1]) begin
          idx   = ID_W'(i - 1);
          found = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (vec[i]) begin
          idx   = ID_W'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pending_encoder_32to5.sv
// Pending request encoder: captures request pulses on 32 lines into a sticky
// pending register, picks the highest-priority unmasked pending line and
// presents its index on a valid/ready output, clearing the line on handshake.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : request/present bus (slave side), see pending_encoder_32to5_if
module pending_encoder_32to5
  import pending_encoder_32to5_pkg::*;
#(
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pending_encoder_32to5_if.slave  bus
);

  state_t           state;
  logic [N_REQ-1:0] pending;
  logic             out_valid;
  logic [ID_W-1:0]  out_id;

  logic [N_REQ-1:0] clear_vec;
  logic [ID_W-1:0]  winner;
  logic             sel_any;

  priority_enc_32to5 #(.LSB_FIRST(LSB_FIRST)) u_prio (
    .vec   (pending & bus.mask_i),
    .idx   (winner),
    .found (sel_any)
  );

  // The presented line is cleared on handshake regardless of its current mask.
  assign clear_vec = (out_valid && bus.out_ready_i) ? id_to_onehot(out_id) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
    end else if (bus.clr_all_i) begin
      state     <= IDLE;
      pending   <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
    end else begin
      // A request arriving in the handshake cycle re-arms the line.
      pending <= (pending & ~clear_vec) | bus.req_i;
      case (state)
        IDLE: begin
          if (sel_any) begin
            out_id    <= winner;
            out_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          // Always return through IDLE: one bubble cycle after each handshake.
          if (bus.out_ready_i) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.out_valid_o   = out_valid;
  assign bus.out_id_o      = out_id;
  assign bus.pending_o     = pending;
  assign bus.any_pending_o = sel_any;

endmodule

// File: tb/tb_pending_encoder_32to5.sv
module tb_pending_encoder_32to5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] req = '0;
  logic [31:0] mask = '1;
  logic        clr = 1'b0;
  logic        rdy = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pending_encoder_32to5_if if_l ();
  pending_encoder_32to5_if if_m ();

  assign if_l.req_i       = req;
  assign if_l.mask_i      = mask;
  assign if_l.clr_all_i   = clr;
  assign if_l.out_ready_i = rdy;
  assign if_m.req_i       = req;
  assign if_m.mask_i      = mask;
  assign if_m.clr_all_i   = clr;
  assign if_m.out_ready_i = rdy;

  pending_encoder_32to5 #(.LSB_FIRST(1)) dut_l (.clk(clk), .rst_n(rst_n), .bus(if_l));
  pending_encoder_32to5 #(.LSB_FIRST(0)) dut_m (.clk(clk), .rst_n(rst_n), .bus(if_m));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // index 0 models LSB_FIRST=1, index 1 models LSB_FIRST=0
  bit [31:0] m_pend[2];
  bit        m_val[2];
  int        m_id[2];

  function automatic int pick(input bit [31:0] s, input bit lsb);
    if (lsb) begin
      for (int i = 0; i < 32; i++) if (s[i]) return i;
    end else begin
      for (int i = 31; i >= 0; i--) if (s[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_pend[d] = '0; m_val[d] = 0; m_id[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (clr) begin
          m_pend[d] = '0; m_val[d] = 0; m_id[d] = 0;
        end else begin
          bit [31:0] np;
          int w;
          bit hs;
          hs = m_val[d] && rdy;
          w  = pick(m_pend[d] & mask, d == 0);
          np = m_pend[d];
          if (hs) np[m_id[d]] = 1'b0;
          np = np | req;
          if (!m_val[d]) begin
            if (w >= 0) begin m_val[d] = 1; m_id[d] = w; end
          end else if (hs) begin
            m_val[d] = 0;
          end
          m_pend[d] = np;
        end
      end
    end
  end

  // per-cycle compare, away from the active edge
  always @(negedge clk) begin
    chk("l_valid",   32'(if_l.out_valid_o),   32'(m_val[0]));
    chk("l_pending", if_l.pending_o,          m_pend[0]);
    chk("l_any",     32'(if_l.any_pending_o), 32'(|(m_pend[0] & mask)));
    if (m_val[0]) chk("l_id", 32'(if_l.out_id_o), 32'(m_id[0]));
    chk("m_valid",   32'(if_m.out_valid_o),   32'(m_val[1]));
    chk("m_pending", if_m.pending_o,          m_pend[1]);
    chk("m_any",     32'(if_m.any_pending_o), 32'(|(m_pend[1] & mask)));
    if (m_val[1]) chk("m_id", 32'(if_m.out_id_o), 32'(m_id[1]));
  end

  // ---------------- stimulus with literal expectations ----------------
  int ql[$];
  int qm[$];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic collect(input int n);
    ql.delete(); qm.delete();
    repeat (n) begin
      tick();
      if (if_l.out_valid_o && rdy) ql.push_back(int'(if_l.out_id_o));
      if (if_m.out_valid_o && rdy) qm.push_back(int'(if_m.out_id_o));
    end
  endtask

  task automatic chk_q(input string name, input int q[$], input int e[$]);
    chk({name, "_n"}, 32'(q.size()), 32'(e.size()));
    for (int i = 0; i < e.size(); i++)
      chk(name, (i < q.size()) ? 32'(q[i]) : 32'hFFFF_FFFF, 32'(e[i]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_valid",   32'(if_l.out_valid_o), 0);
    chk("rst_id",      32'(if_l.out_id_o), 0);
    chk("rst_pending", if_l.pending_o, 0);
    chk("rst_any",     32'(if_l.any_pending_o), 0);

    // single request, held presentation
    req = 32'h0000_0020; tick(); req = '0; tick();
    chk("single_valid", 32'(if_l.out_valid_o), 1);
    chk("single_id",    32'(if_l.out_id_o), 5);
    repeat (3) begin
      tick();
      chk("hold_valid", 32'(if_l.out_valid_o), 1);
      chk("hold_id",    32'(if_l.out_id_o), 5);
    end
    rdy = 1'b1; tick();
    chk("single_clr_pending", if_l.pending_o, 0);
    chk("single_clr_valid",   32'(if_l.out_valid_o), 0);

    // priority ordering, ready held high
    req = 32'h8000_0011; tick(); req = '0;
    collect(8);
    chk_q("prio_lsb", ql, '{0, 4, 31});
    chk_q("prio_msb", qm, '{31, 4, 0});

    // masking
    mask = 32'hFFFF_FFFE; req = 32'h0000_0003; tick(); req = '0;
    collect(6);
    chk_q("mask_l", ql, '{1});
    chk_q("mask_m", qm, '{1});
    chk("mask_pending", if_l.pending_o, 32'h1);
    chk("mask_any",     32'(if_l.any_pending_o), 0);
    mask = '1;
    collect(4);
    chk_q("unmask_l", ql, '{0});
    chk("unmask_pending", if_l.pending_o, 0);

    // re-request in the handshake cycle
    rdy = 1'b0; req = 32'h80; tick(); req = '0; tick();
    chk("re_valid0", 32'(if_l.out_valid_o), 1);
    chk("re_id0",    32'(if_l.out_id_o), 7);
    rdy = 1'b1; req = 32'h80; tick();
    chk("re_pending", if_l.pending_o, 32'h80);
    chk("re_bubble",  32'(if_l.out_valid_o), 0);
    req = '0; rdy = 1'b0; tick();
    chk("re_valid1", 32'(if_l.out_valid_o), 1);
    chk("re_id1",    32'(if_l.out_id_o), 7);
    rdy = 1'b1; tick();
    chk("re_done", if_l.pending_o, 0);
    rdy = 1'b0;

    // clear-all beats requests and handshake
    req = 32'h104; tick(); req = '0; tick();
    chk("clr_pre_id", 32'(if_l.out_id_o), 2);
    chk("clr_pre_id_m", 32'(if_m.out_id_o), 8);
    clr = 1'b1; req = '1; rdy = 1'b1; tick();
    chk("clr_pending", if_l.pending_o, 0);
    chk("clr_valid",   32'(if_l.out_valid_o), 0);
    chk("clr_any",     32'(if_l.any_pending_o), 0);
    clr = 1'b0; req = '0; rdy = 1'b0; tick();
    chk("clr_after", 32'(if_l.out_valid_o), 0);

    // async reset while presenting
    req = 32'h104; tick(); req = '0; tick();
    chk("arst_pre_pending", if_l.pending_o, 32'h104);
    chk("arst_pre_valid",   32'(if_l.out_valid_o), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid",   32'(if_l.out_valid_o), 0);
    chk("arst_id",      32'(if_l.out_id_o), 0);
    chk("arst_pending", if_l.pending_o, 0);
    chk("arst_any",     32'(if_l.any_pending_o), 0);
    tick(); rst_n = 1'b1;
    repeat (2) tick();
    chk("arst_release", 32'(if_l.out_valid_o), 0);

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      req  = $urandom & $urandom & $urandom & $urandom;
      mask = $urandom | $urandom;
      rdy  = 1'($urandom_range(0, 1));
      clr  = ($urandom_range(0, 63) == 0);
      tick();
    end
    req = '0; clr = 1'b0; rdy = 1'b0;
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
